// File: rtl/uart_bus_if.sv
// Bus between the polling master and the UART MMIO responder (STATUS at +0x00, DATA at +0x04).
interface uart_bus_if;
  logic [31:0] addr;
  logic [7:0]  write_data;
  logic        write_enable;
  logic        read_enable;
  logic [7:0]  read_data;

  modport master (
    output addr,
    output write_data,
    output write_enable,
    output read_enable,
    input  read_data
  );

  modport slave (
    input  addr,
    input  write_data,
    input  write_enable,
    input  read_enable,
    output read_data
  );
endinterface

// File: rtl/uart_bus_master.sv
// Polling bus initiator for the UART MMIO peripheral. It reads STATUS, then moves
// at most one byte per poll between the host streams and the UART FIFOs, holding
// one byte per direction.
//
// state  | meaning
// IDLE   | no strobe; counts down the poll gap, then polls if any work is possible
// STATUS | read STATUS, pick a direction (alternating when both are possible)
// WRITE  | write the held TX byte to DATA
// READ   | read DATA into the RX holding register
module uart_bus_master #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned POLL_GAP  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tx_byte,
  input  logic       tx_byte_valid,
  output logic       tx_byte_ready,
  output logic [7:0] rx_byte,
  output logic       rx_byte_valid,
  input  logic       rx_byte_ready,
  uart_bus_if.master bus,
  output logic [1:0] last_status
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STATUS = 2'd1;
  localparam logic [1:0] S_WRITE  = 2'd2;
  localparam logic [1:0] S_READ   = 2'd3;

  localparam logic SERVED_RX = 1'b0;
  localparam logic SERVED_TX = 1'b1;

  localparam logic [31:0] STATUS_ADDR = BASE_ADDR + 32'h0000_0000;
  localparam logic [31:0] DATA_ADDR   = BASE_ADDR + 32'h0000_0004;
  localparam logic [7:0]  GAP_LOAD    = 8'(POLL_GAP);

  logic [1:0] state;
  logic [7:0] tx_hold;
  logic [7:0] rx_hold;
  logic       tx_hold_full;
  logic       rx_hold_full;
  logic [7:0] gap_cnt;
  logic       last_served;

  logic can_tx;
  logic can_rx;
  logic tx_accept;
  logic rx_pop;

  // Decisions are made from registered hold flags only, so a host pop during
  // STATUS cannot turn that same poll into a READ.
  always_comb begin
    can_tx    = tx_hold_full && bus.read_data[0];
    can_rx    = !rx_hold_full && bus.read_data[1];
    tx_accept = tx_byte_valid && !tx_hold_full;
    rx_pop    = rx_hold_full && rx_byte_ready;
  end

  // Sequencer state, last sampled status and round-robin memory.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      last_served <= SERVED_RX;
      last_status <= 2'b00;
    end else begin
      case (state)
        S_IDLE: begin
          if (gap_cnt == 8'd0 && (tx_hold_full || !rx_hold_full))
            state <= S_STATUS;
        end
        S_STATUS: begin
          last_status <= bus.read_data[1:0];
          if (can_tx && can_rx)
            state <= (last_served == SERVED_RX) ? S_WRITE : S_READ;
          else if (can_tx)
            state <= S_WRITE;
          else if (can_rx)
            state <= S_READ;
          else
            state <= S_IDLE;
        end
        S_WRITE: begin
          last_served <= SERVED_TX;
          state       <= S_IDLE;
        end
        S_READ: begin
          last_served <= SERVED_RX;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Poll-gap down-counter; a new host byte cancels any pending gap.
  always_ff @(posedge clk) begin
    if (reset)
      gap_cnt <= 8'd0;
    else if (tx_accept)
      gap_cnt <= 8'd0;
    else if (state == S_STATUS && !can_tx && !can_rx)
      gap_cnt <= GAP_LOAD;
    else if (state == S_IDLE && gap_cnt != 8'd0)
      gap_cnt <= gap_cnt - 8'd1;
  end

  // TX holding register: filled by the host, emptied by the WRITE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_hold      <= 8'h00;
      tx_hold_full <= 1'b0;
    end else if (tx_accept) begin
      tx_hold      <= tx_byte;
      tx_hold_full <= 1'b1;
    end else if (state == S_WRITE) begin
      tx_hold_full <= 1'b0;
    end
  end

  // RX holding register: filled by the READ cycle, emptied by the host.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_hold      <= 8'h00;
      rx_hold_full <= 1'b0;
    end else if (state == S_READ) begin
      rx_hold      <= bus.read_data;
      rx_hold_full <= 1'b1;
    end else if (rx_pop) begin
      rx_hold_full <= 1'b0;
    end
  end

  // Bus outputs decode the state register only; address and data idle at zero.
  always_comb begin
    bus.addr         = 32'h0000_0000;
    bus.write_data   = 8'h00;
    bus.write_enable = 1'b0;
    bus.read_enable  = 1'b0;
    case (state)
      S_STATUS: begin
        bus.read_enable = 1'b1;
        bus.addr        = STATUS_ADDR;
      end
      S_WRITE: begin
        bus.write_enable = 1'b1;
        bus.addr         = DATA_ADDR;
        bus.write_data   = tx_hold;
      end
      S_READ: begin
        bus.read_enable = 1'b1;
        bus.addr        = DATA_ADDR;
      end
      default: ;
    endcase
  end

  assign tx_byte_ready = !tx_hold_full;
  assign rx_byte_valid = rx_hold_full;
  assign rx_byte       = rx_hold;

endmodule
